snd_seq: RTL and testbench

// Timed register-write scheduler and bus arbiter in front of sndgen. CPU queues events
// {delay, sndgen reg addr, data} into a FIFO; block replays each as a sndgen register

---
 rtl/snd_seq_pkg.sv | 39 +++
 rtl/snd_seq_fifo.sv | 63 ++++++
 rtl/snd_seq.sv | 217 +++++++++++++++++++++
 tb/tb_snd_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_seq_pkg.sv
// Shared definitions for the sndgen event sequencer: local register map,
// STATUS bit positions, event word layout and sequencer state encoding.
package snd_seq_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h80;
  localparam logic [7:0] REG_EVT_DATA = 8'h84;
  localparam logic [7:0] REG_EVT_CMD  = 8'h88;
  localparam logic [7:0] REG_STATUS   = 8'h8C;

  localparam int BIT_FULL  = 8;
  localparam int BIT_EMPTY = 9;
  localparam int BIT_BUSY  = 10;
  localparam int BIT_OVF   = 11;

  localparam int EVT_W = 56;

  typedef struct packed {
    logic [15:0] delay;
    logic [7:0]  addr;
    logic [31:0] data;
  } evt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_ISSUE
  } seq_state_e;

  // EVT_CMD carries delay in [31:16] and the sndgen register address in [7:0]
  function automatic evt_t make_evt(input logic [31:0] cmd, input logic [31:0] data);
    evt_t e;
    e.delay = cmd[31:16];
    e.addr  = cmd[7:0];
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/snd_seq_fifo.sv
// Event FIFO for the sequencer. Synchronous read port with no reset on the
// storage or read register so the array maps onto block RAM.
module snd_seq_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
    rdata <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snd_seq.sv
// Timed register-write scheduler in front of sndgen: replays queued events
// after a tick delay and shares the sndgen master port with CPU passthrough.
module snd_seq
  import snd_seq_pkg::*;
#(
  parameter int DIV   = 24000,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic [3:0]  we,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        snd_cs,
  output logic [3:0]  snd_we,
  output logic [7:0]  snd_addr,
  output logic [31:0] snd_din
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DIV);

  logic          cpu_wr, cpu_rd, pass_wr, loc_wr;
  logic          ctrl_wr, data_wr, push_req;
  logic          run, flush_q, ovf;
  logic [31:0]   evt_data;
  logic [PW-1:0] presc;
  logic          tick;

  logic          full, empty, pop;
  logic [LW-1:0] level;
  logic [EVT_W-1:0] fifo_rdata;
  evt_t          push_evt, head;

  seq_state_e    state, state_d;
  logic [15:0]   cnt, cnt_d;
  logic          load, fire;
  logic [7:0]    ev_addr_q;
  logic [31:0]   ev_data_q;

  logic [31:0]   status, rd_mux;

  assign cpu_wr   = cs && (we != 4'b0000);
  assign cpu_rd   = cs && (we == 4'b0000);
  assign pass_wr  = cpu_wr && !addr[7];
  assign loc_wr   = cpu_wr && addr[7];
  assign ctrl_wr  = loc_wr && (addr == REG_CTRL);
  assign data_wr  = loc_wr && (addr == REG_EVT_DATA);
  assign push_req = loc_wr && (addr == REG_EVT_CMD) && !flush_q;
  assign push_evt = make_evt(din, evt_data);
  assign head     = fifo_rdata;
  assign tick     = run && (presc == PW'(DIV - 1));

  snd_seq_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop),
    .flush   (flush_q),
    .wdata   (push_evt),
    .rdata   (fifo_rdata),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Flush is applied one cycle after the CTRL write and overrides any push then
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      flush_q  <= 1'b0;
      ovf      <= 1'b0;
      evt_data <= '0;
    end else begin
      flush_q <= ctrl_wr && din[1];
      if (ctrl_wr)
        run <= din[0];
      if (data_wr)
        evt_data <= din;
      if (flush_q)
        ovf <= 1'b0;
      else if (push_req && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      presc <= '0;
    else if (!run)
      presc <= '0;
    else if (presc == PW'(DIV - 1))
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  // A tick seen during LOAD already counts; the final tick issues straight
  // from WAIT so a delay of D lands within ((D-1)*DIV, D*DIV] cycles of LOAD.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    fire    = 1'b0;
    if (flush_q) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (run && !empty)
            state_d = S_LOAD;
        end
        S_LOAD: begin
          pop  = 1'b1;
          load = 1'b1;
          if (head.delay == 16'd0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = head.delay - {15'd0, tick};
          end
        end
        S_WAIT: begin
          if (run && ((cnt == 16'd0) || (tick && cnt == 16'd1))) begin
            cnt_d = 16'd0;
            if (pass_wr) begin
              state_d = S_ISSUE;
            end else begin
              fire    = 1'b1;
              state_d = S_IDLE;
            end
          end else if (tick) begin
            cnt_d = cnt - 16'd1;
          end
        end
        S_ISSUE: begin
          if (!pass_wr) begin
            fire    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ev_addr_q <= '0;
      ev_data_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        ev_addr_q <= head.addr;
        ev_data_q <= head.data;
      end
    end
  end

  always_comb begin
    status                 = '0;
    status[4:0]            = 5'(level);
    status[BIT_FULL]       = full;
    status[BIT_EMPTY]      = empty;
    status[BIT_BUSY]       = (state != S_IDLE);
    status[BIT_OVF]        = ovf;
  end

  always_comb begin
    rd_mux = '0;
    if (addr[7]) begin
      case (addr)
        REG_CTRL:     rd_mux = {30'd0, flush_q, run};
        REG_EVT_DATA: rd_mux = evt_data;
        REG_STATUS:   rd_mux = status;
        default:      rd_mux = '0;
      endcase
    end
  end

  // CPU passthrough always wins the master port; sequencer writes retry from ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout     <= '0;
      snd_cs   <= 1'b0;
      snd_we   <= '0;
      snd_addr <= '0;
      snd_din  <= '0;
    end else begin
      snd_cs <= 1'b0;
      snd_we <= 4'h0;
      if (pass_wr) begin
        snd_cs   <= 1'b1;
        snd_we   <= we;
        snd_addr <= addr;
        snd_din  <= din;
      end else if (fire) begin
        snd_cs   <= 1'b1;
        snd_we   <= 4'hF;
        snd_addr <= ev_addr_q;
        snd_din  <= ev_data_q;
      end
      if (cpu_rd)
        dout <= rd_mux;
    end
  end

endmodule

// File: tb/tb_snd_seq.sv
// Directed testbench for snd_seq with DIV=4, DEPTH=4; expected values are
// hand-derived and the sndgen master port is probed directly.
module tb_snd_seq;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        cs;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        snd_cs;
  logic [3:0]  snd_we;
  logic [7:0]  snd_addr;
  logic [31:0] snd_din;

  int errors = 0;
  int checks = 0;

  snd_seq #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .snd_cs   (snd_cs),
    .snd_we   (snd_we),
    .snd_addr (snd_addr),
    .snd_din  (snd_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    cs   = 1'b0;
    we   = 4'h0;
    addr = 8'h00;
    din  = 32'h0;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [31:0] d);
    cs   = 1'b1;
    we   = 4'hF;
    addr = a;
    din  = d;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_write(a, d);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs   = 1'b1;
    we   = 4'h0;
    addr = a;
    @(negedge clk);
    bus_idle();
    d = dout;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus_idle();
    reset_n = 1'b0;
    #100;
    checks++; if (snd_cs !== 1'b0) begin errors++; $display("[TB] FAIL reset_snd_cs: got %b expected 0", snd_cs); end
    checks++; if (snd_we !== 4'h0) begin errors++; $display("[TB] FAIL reset_snd_we: got %h expected 0", snd_we); end
    checks++; if (snd_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_snd_addr: got %h expected 00", snd_addr); end
    checks++; if (snd_din !== 32'h0) begin errors++; $display("[TB] FAIL reset_snd_din: got %h expected 0", snd_din); end
    checks++; if (dout !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read(8'h8C, rd);
    checks++; if (rd !== 32'h200) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000200", rd); end
  endtask

  task automatic test_passthrough();
    cpu_write(8'h04, 32'h1234);
    checks++; if (snd_cs !== 1'b1) begin errors++; $display("[TB] FAIL pass_cs: got %b expected 1", snd_cs); end
    checks++; if (snd_we !== 4'hF) begin errors++; $display("[TB] FAIL pass_we: got %h expected F", snd_we); end
    checks++; if (snd_addr !== 8'h04) begin errors++; $display("[TB] FAIL pass_addr: got %h expected 04", snd_addr); end
    checks++; if (snd_din !== 32'h1234) begin errors++; $display("[TB] FAIL pass_din: got %h expected 00001234", snd_din); end
    @(negedge clk);
    checks++; if (snd_cs !== 1'b0) begin errors++; $display("[TB] FAIL pass_single_cycle: got %b expected 0", snd_cs); end
  endtask

  task automatic test_timed_event();
    logic [31:0] rd;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  w;
    int          n;
    int          lat;
    bit          found;
    cpu_write(8'h84, 32'h0000_CAFE);
    cpu_write(8'h88, 32'h0003_0010);
    @(negedge clk);
    drive_write(8'h80, 32'h1);
    found = 1'b0;
    n = 0;
    a = '0; d = '0; w = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus_idle();
      if (snd_cs === 1'b1) begin
        found = 1'b1;
        n = i;
        a = snd_addr;
        d = snd_din;
        w = snd_we;
        break;
      end
    end
    // run is sampled at edge E, LOAD occupies the cycle after, so LOAD-relative latency is n-2
    lat = n - 2;
    checks++; if (!found) begin errors++; $display("[TB] FAIL timed_timeout: got no write expected write within 40 cycles"); end
    checks++; if (found && (lat < 9 || lat > 12)) begin errors++; $display("[TB] FAIL timed_latency: got %0d expected 9..12", lat); end
    checks++; if (a !== 8'h10) begin errors++; $display("[TB] FAIL timed_addr: got %h expected 10", a); end
    checks++; if (d !== 32'hCAFE) begin errors++; $display("[TB] FAIL timed_data: got %h expected 0000CAFE", d); end
    checks++; if (w !== 4'hF) begin errors++; $display("[TB] FAIL timed_we: got %h expected F", w); end
    @(negedge clk);
    checks++; if (snd_cs !== 1'b0) begin errors++; $display("[TB] FAIL timed_single: got %b expected 0", snd_cs); end
    cpu_read(8'h8C, rd);
    checks++; if (rd !== 32'h200) begin errors++; $display("[TB] FAIL timed_status: got %h expected 00000200", rd); end
  endtask

  task automatic test_order_overflow();
    logic [15:0] dl [4];
    logic [7:0]  ad [4];
    logic [31:0] dt [4];
    logic [7:0]  got_a [8];
    logic [31:0] got_d [8];
    logic [31:0] rd;
    int          nw;
    dl = '{16'd0, 16'd0, 16'd2, 16'd1};
    ad = '{8'h20, 8'h21, 8'h22, 8'h23};
    dt = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    cpu_write(8'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_write(8'h84, dt[i]);
      cpu_write(8'h88, {dl[i], 8'h00, ad[i]});
    end
    cpu_write(8'h84, 32'hDEAD_DEAD);
    cpu_write(8'h88, {16'd0, 8'h00, 8'h2F});
    cpu_read(8'h8C, rd);
    checks++; if (rd !== 32'h904) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 00000904", rd); end
    cpu_write(8'h80, 32'h2);
    cpu_read(8'h8C, rd);
    checks++; if (rd !== 32'h200) begin errors++; $display("[TB] FAIL flush_status: got %h expected 00000200", rd); end
    for (int i = 0; i < 4; i++) begin
      cpu_write(8'h84, dt[i] ^ 32'h0F0F_0000);
      cpu_write(8'h88, {dl[i], 8'h00, ad[i]});
    end
    cpu_write(8'h80, 32'h1);
    nw = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (snd_cs === 1'b1) begin
        if (nw < 8) begin
          got_a[nw] = snd_addr;
          got_d[nw] = snd_din;
        end
        nw++;
      end
    end
    checks++; if (nw != 4) begin errors++; $display("[TB] FAIL order_count: got %0d expected 4", nw); end
    for (int i = 0; i < 4; i++) begin
      if (i < nw) begin
        checks++; if (got_a[i] !== ad[i]) begin errors++; $display("[TB] FAIL order_addr%0d: got %h expected %h", i, got_a[i], ad[i]); end
        checks++; if (got_d[i] !== (dt[i] ^ 32'h0F0F_0000)) begin errors++; $display("[TB] FAIL order_data%0d: got %h expected %h", i, got_d[i], dt[i] ^ 32'h0F0F_0000); end
      end
    end
  endtask

  task automatic test_collision();
    cpu_write(8'h80, 32'h0);
    cpu_write(8'h84, 32'h0000_BEEF);
    cpu_write(8'h88, {16'd0, 8'h00, 8'h30});
    @(negedge clk);
    drive_write(8'h80, 32'h1);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    // the sequencer sits in ISSUE during this cycle
    drive_write(8'h08, 32'h5555);
    @(negedge clk);
    bus_idle();
    checks++; if (snd_cs !== 1'b1 || snd_addr !== 8'h08 || snd_din !== 32'h5555) begin errors++; $display("[TB] FAIL coll_cpu: got cs=%b addr=%h data=%h expected cs=1 addr=08 data=00005555", snd_cs, snd_addr, snd_din); end
    @(negedge clk);
    checks++; if (snd_cs !== 1'b1 || snd_addr !== 8'h30 || snd_din !== 32'hBEEF) begin errors++; $display("[TB] FAIL coll_seq: got cs=%b addr=%h data=%h expected cs=1 addr=30 data=0000BEEF", snd_cs, snd_addr, snd_din); end
    checks++; if (snd_we !== 4'hF) begin errors++; $display("[TB] FAIL coll_seq_we: got %h expected F", snd_we); end
    @(negedge clk);
    checks++; if (snd_cs !== 1'b0) begin errors++; $display("[TB] FAIL coll_after: got %b expected 0", snd_cs); end
  endtask

  task automatic test_pause_abort();
    logic [31:0] rd;
    int          early;
    int          n;
    int          nw;
    bit          found;
    cpu_write(8'h80, 32'h0);
    cpu_write(8'h84, 32'h0000_0077);
    cpu_write(8'h88, {16'd3, 8'h00, 8'h40});
    @(negedge clk);
    drive_write(8'h80, 32'h1);
    early = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1 || i == 5) bus_idle();
      if (i == 4) drive_write(8'h80, 32'h0);
      if (i == 25) drive_write(8'h80, 32'h1);
      if (snd_cs === 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("[TB] FAIL pause_no_write: got %0d writes expected 0", early); end
    found = 1'b0;
    n = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) bus_idle();
      if (snd_cs === 1'b1) begin
        found = 1'b1;
        n = j;
        checks++; if (snd_addr !== 8'h40 || snd_din !== 32'h77) begin errors++; $display("[TB] FAIL resume_event: got addr=%h data=%h expected addr=40 data=00000077", snd_addr, snd_din); end
        break;
      end
    end
    // two ticks remain after the pause and the prescaler restarts from 0
    checks++; if (!found || (n - 1) < DIV + 1 || (n - 1) > 2 * DIV + 2) begin errors++; $display("[TB] FAIL resume_latency: got found=%0d cycles=%0d expected %0d..%0d", found, n - 1, DIV + 1, 2 * DIV + 2); end

    cpu_write(8'h84, 32'h0000_0099);
    cpu_write(8'h88, {16'd3, 8'h00, 8'h50});
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (snd_cs === 1'b1) nw++;
    end
    reset_n = 1'b0;
    #20;
    checks++; if (snd_cs !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_reset: got %b expected 0", snd_cs); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (snd_cs === 1'b1) nw++;
    end
    checks++; if (nw != 0) begin errors++; $display("[TB] FAIL abort_no_write: got %0d writes expected 0", nw); end
    cpu_read(8'h8C, rd);
    checks++; if (rd !== 32'h200) begin errors++; $display("[TB] FAIL abort_status: got %h expected 00000200", rd); end
    cpu_read(8'h80, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_ctrl: got %h expected 00000000", rd); end
  endtask

  initial begin
    reset_n = 1'b1;
    bus_idle();
    test_reset();
    test_passthrough();
    test_timed_event();
    test_order_overflow();
    test_collision();
    test_pause_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
